// File: rtl/a2d_pkg.sv
// Shared constants, channel map and FSM state type for the A2D interface.
// Macro A2D_BATT_CHAN_EN adds the battery channel to the round robin.
package a2d_pkg;

  localparam int SCLK_DIV_W = 5;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

`ifdef A2D_BATT_CHAN_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CNV,
    GAP,
    RD
  } a2d_state_t;

  // Round-robin slot to physical ADC channel.
  function automatic logic [2:0] idx2chnl(input logic [1:0] idx);
    case (idx)
      2'd0:    idx2chnl = CH_LFT;
      2'd1:    idx2chnl = CH_RGHT;
      2'd2:    idx2chnl = CH_STEER;
      default: idx2chnl = CH_BATT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_intf_spi_mnrch.sv
// 16-bit SPI master: SCLK = clk/32 idling high, MOSI shifts on SCLK fall,
// MISO sampled on SCLK rise. Built identically with or without A2D_BATT_CHAN_EN.
module spi_mnrch
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] resp,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_IDLE = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

  logic [SCLK_DIV_W-1:0] sclk_div;
  logic [3:0]            bit_cnt;
  logic [15:0]           shft;
  logic                  miso_smpl;
  logic                  busy;
  logic                  smpl;
  logic                  shift;

  assign smpl  = busy && (sclk_div == DIV_RISE);
  assign shift = busy && (sclk_div == DIV_FALL);
  assign done  = shift && (bit_cnt == 4'hF);

  assign SCLK = sclk_div[SCLK_DIV_W-1];
  assign MOSI = shft[15] & ~SS_n;
  assign resp = shft;

  // The 16th falling edge is suppressed: the divider parks high instead, so
  // SS_n rises exactly 16 SCLK periods after it fell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      sclk_div  <= DIV_IDLE;
      bit_cnt   <= 4'h0;
      shft      <= 16'h0000;
      miso_smpl <= 1'b0;
    end else if (wrt && !busy) begin
      busy     <= 1'b1;
      SS_n     <= 1'b0;
      sclk_div <= '0;
      bit_cnt  <= 4'h0;
      shft     <= cmd;
    end else if (busy) begin
      if (smpl) miso_smpl <= MISO;
      if (shift) begin
        shft    <= {shft[14:0], miso_smpl};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (done) begin
        busy     <= 1'b0;
        SS_n     <= 1'b1;
        sclk_div <= DIV_IDLE;
      end else begin
        sclk_div <= sclk_div + SCLK_DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin ADC reader: convert command, 1-clk SS_n gap, read command.
// Macro A2D_BATT_CHAN_EN includes the battery channel; otherwise batt is tied to zero.
module a2d_intf
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  a2d_state_t  state, nxt_state;
  logic        wrt;
  logic        done;
  logic        rd_done;
  logic [15:0] cmd;
  logic [15:0] resp;
  logic [3:0]  unused_resp_hi;
  logic [1:0]  rr_idx;
  logic [1:0]  wr_idx;
  logic        upd;
  logic [11:0] lft_q, rght_q, steer_q;
`ifdef A2D_BATT_CHAN_EN
  logic [11:0] batt_q;
`endif

  assign cmd            = {2'b00, idx2chnl(rr_idx), 11'h000};
  assign unused_resp_hi = resp[15:12];

  spi_mnrch u_spi (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt),
    .cmd   (cmd),
    .done  (done),
    .resp  (resp),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // done is combinational on the last SCLK edge, so launching the read from
  // GAP gives exactly one clk of SS_n high between the two transactions.
  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        wrt       = 1'b1;
        nxt_state = CNV;
      end
      CNV: if (done) nxt_state = GAP;
      GAP: begin
        wrt       = 1'b1;
        nxt_state = RD;
      end
      RD: if (done) begin
        rd_done   = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Index advances with RD completion so a back-to-back nxt already sees the
  // next channel; the write target is latched for the following clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_idx <= 2'd0;
      wr_idx <= 2'd0;
      upd    <= 1'b0;
    end else begin
      upd <= rd_done;
      if (rd_done) begin
        wr_idx <= rr_idx;
        rr_idx <= (rr_idx == LAST_IDX) ? 2'd0 : rr_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
`ifdef A2D_BATT_CHAN_EN
      batt_q  <= 12'h000;
`endif
    end else if (upd) begin
      case (wr_idx)
        2'd0: lft_q   <= resp[11:0];
        2'd1: rght_q  <= resp[11:0];
        2'd2: steer_q <= resp[11:0];
`ifdef A2D_BATT_CHAN_EN
        2'd3: batt_q  <= resp[11:0];
`endif
        default: ;
      endcase
    end
  end

  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
`ifdef A2D_BATT_CHAN_EN
  assign batt      = batt_q;
`else
  assign batt      = 12'h000;
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf with a behavioural ADC on the SPI pins.
// Expectations follow A2D_BATT_CHAN_EN the same way the design does.
module tb_a2d_intf;

  localparam longint CLK_T = 10;

`ifdef A2D_BATT_CHAN_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        SS_n, SCLK, MOSI;
  logic        MISO = 1'b0;

  a2d_intf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ADC model state and SPI observations
  logic [11:0] adc_val [8];
  logic [15:0] resp_word = '0;
  logic [15:0] mosi_word = '0;
  logic [15:0] last_cmd  = '0;
  logic [15:0] prev_cmd  = '0;
  logic [2:0]  last_chnl = 3'd0;
  logic [3:0]  junk;
  logic        ss_q      = 1'b1;
  logic        sclk_q    = 1'b1;
  int          rcnt      = 16;
  int          ss_fall_cnt = 0;
  int          ss_rise_cnt = 0;
  longint      ss_fall_t = 0, ss_rise_t = 0, sclk_rise_t = 0;
  longint      gap_len = 0, low_len = 0, sclk_per = 0;

  // Reference model: which output slot a conversion lands in
  int          order [4] = '{0, 4, 5, 6};
  logic [11:0] exp_out [4];
  int          conv_num = 0;

  typedef struct packed {
    logic [11:0] v0, v4, v5, v6;
    logic [11:0] e_lft, e_rght, e_steer, e_batt;
  } vec_t;
  vec_t tbl [5];

  // ADC: word launched at SS_n fall, next bit on each SCLK fall; answers
  // with the channel named by the previous command, junk in the top nibble.
  always @(SS_n or SCLK) begin
    if (ss_q && !SS_n) begin
      junk        = 4'($urandom_range(1, 15));
      resp_word   = {junk, adc_val[last_chnl]};
      MISO        = resp_word[15];
      rcnt        = 0;
      mosi_word   = '0;
      ss_fall_cnt = ss_fall_cnt + 1;
      gap_len     = $time - ss_rise_t;
      ss_fall_t   = $time;
    end else if (!ss_q && SS_n) begin
      ss_rise_cnt = ss_rise_cnt + 1;
      ss_rise_t   = $time;
      low_len     = $time - ss_fall_t;
      prev_cmd    = last_cmd;
      last_cmd    = mosi_word;
      last_chnl   = mosi_word[13:11];
    end else if (!SS_n && !sclk_q && SCLK) begin
      mosi_word = {mosi_word[14:0], MOSI};
      if (rcnt > 0) sclk_per = $time - sclk_rise_t;
      sclk_rise_t = $time;
      rcnt = rcnt + 1;
    end else if (!SS_n && sclk_q && !SCLK && rcnt > 0 && rcnt < 16) begin
      MISO = resp_word[15 - rcnt];
    end
    ss_q   = SS_n;
    sclk_q = SCLK;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyReset(input logic hold_nxt);
    @(negedge clk);
    rst_n = 1'b0;
    nxt   = hold_nxt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    conv_num = 0;
    for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  // Optionally pulse nxt, optionally re-pulse at clk extra_at (must be
  // ignored), wait for both SS_n rises, then one clk for the result write.
  // With chain set, nxt is raised in the clk the FSM is back in IDLE.
  task automatic applyStimulus(input int extra_at, input logic chain, input logic pulse, output int lat);
    int r0;
    r0  = ss_rise_cnt;
    lat = 0;
    if (pulse) begin
      nxt = 1'b1;
      @(negedge clk);
    end
    nxt = 1'b0;
    while (ss_rise_cnt < r0 + 2 && lat < 1100) begin
      @(negedge clk);
      lat++;
      nxt = (extra_at != 0 && lat == extra_at);
    end
    checkOutput("conv_done", 16'(ss_rise_cnt - r0), 16'd2);
    nxt = chain;
    @(negedge clk);
    lat++;
    nxt = 1'b0;
  endtask

  task automatic modelConv(output logic [2:0] ch);
    int pos;
    pos = conv_num % NCH;
    ch  = 3'(order[pos]);
    exp_out[pos] = adc_val[ch];
    conv_num++;
  endtask

  task automatic checkAll(input string tag, input logic [2:0] ch);
    checkOutput({tag, "_lft"},   16'(lft_ld),    16'(exp_out[0]));
    checkOutput({tag, "_rght"},  16'(rght_ld),   16'(exp_out[1]));
    checkOutput({tag, "_steer"}, 16'(steer_pot), 16'(exp_out[2]));
    checkOutput({tag, "_batt"},  16'(batt),      16'(exp_out[3]));
    checkOutput({tag, "_rdcmd"}, last_cmd, {2'b00, ch, 11'h000});
    checkOutput({tag, "_cnvcmd"}, prev_cmd, {2'b00, ch, 11'h000});
  endtask

  initial begin
    int          lat;
    int          f0;
    int          w;
    logic [2:0]  ch;
    logic [15:0] ok;

    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
    rst_n = 1'b0;
    nxt   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ss_n",  16'(SS_n), 16'd1);
    checkOutput("rst_sclk",  16'(SCLK), 16'd1);
    checkOutput("rst_mosi",  16'(MOSI), 16'd0);
    checkOutput("rst_lft",   16'(lft_ld), 16'h000);
    checkOutput("rst_rght",  16'(rght_ld), 16'h000);
    checkOutput("rst_steer", 16'(steer_pot), 16'h000);
    checkOutput("rst_batt",  16'(batt), 16'h000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single conversion of ch 0, with SPI timing checks
    adc_val[0] = 12'hA5C;
    f0 = ss_fall_cnt;
    applyStimulus(0, 1'b0, 1'b1, lat);
    checkOutput("c0_lft",   16'(lft_ld), 16'hA5C);
    checkOutput("c0_rght",  16'(rght_ld), 16'h000);
    checkOutput("c0_steer", 16'(steer_pot), 16'h000);
    checkOutput("c0_batt",  16'(batt), 16'h000);
    checkOutput("c0_cmd_ch", 16'(last_cmd[13:11]), 16'd0);
    ok = (lat >= 1025 && lat <= 1040) ? 16'd1 : 16'd0;
    checkOutput("c0_latency_ok", ok, 16'd1);
    checkOutput("sclk_period", 16'(sclk_per), 16'(32 * CLK_T));
    checkOutput("ss_low_len",  16'(low_len), 16'(512 * CLK_T));
    checkOutput("gap_len",     16'(gap_len), 16'(CLK_T));
    checkOutput("c0_ss_pairs", 16'(ss_fall_cnt - f0), 16'd2);

    // nxt re-pulsed 100 clk into a conversion must be dropped
    adc_val[4] = 12'h5A5;
    f0 = ss_fall_cnt;
    applyStimulus(100, 1'b0, 1'b1, lat);
    repeat (60) @(negedge clk);
    checkOutput("ign_ss_pairs", 16'(ss_fall_cnt - f0), 16'd2);
    checkOutput("ign_rght", 16'(rght_ld), 16'h5A5);
    checkOutput("ign_lft",  16'(lft_ld), 16'hA5C);

    // table: round robin from reset
    tbl[0] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h111, 12'h000, 12'h000, 12'h000};
    tbl[1] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h111, 12'h222, 12'h000, 12'h000};
    tbl[2] = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h111, 12'h222, 12'h333, 12'h000};
`ifdef A2D_BATT_CHAN_EN
    tbl[3] = '{12'h666, 12'h222, 12'h333, 12'h444, 12'h111, 12'h222, 12'h333, 12'h444};
    tbl[4] = '{12'h555, 12'h777, 12'h333, 12'h444, 12'h555, 12'h222, 12'h333, 12'h444};
`else
    tbl[3] = '{12'h666, 12'h222, 12'h333, 12'h444, 12'h666, 12'h222, 12'h333, 12'h000};
    tbl[4] = '{12'h555, 12'h777, 12'h333, 12'h444, 12'h666, 12'h777, 12'h333, 12'h000};
`endif
    applyReset(1'b0);
    for (int i = 0; i < 5; i++) begin
      adc_val[0] = tbl[i].v0;
      adc_val[4] = tbl[i].v4;
      adc_val[5] = tbl[i].v5;
      adc_val[6] = tbl[i].v6;
      applyStimulus(0, 1'b0, 1'b1, lat);
      checkOutput($sformatf("tbl%0d_lft", i),   16'(lft_ld),    16'(tbl[i].e_lft));
      checkOutput($sformatf("tbl%0d_rght", i),  16'(rght_ld),   16'(tbl[i].e_rght));
      checkOutput($sformatf("tbl%0d_steer", i), 16'(steer_pot), 16'(tbl[i].e_steer));
      checkOutput($sformatf("tbl%0d_batt", i),  16'(batt),      16'(tbl[i].e_batt));
    end

    // async reset in the low half of SCLK period 8 of the read transaction
    f0 = ss_fall_cnt;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    w = 0;
    while (!(ss_fall_cnt == f0 + 2 && rcnt == 7 && SCLK == 1'b0) && w < 1100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rd_p8_reached", 16'(ss_fall_cnt - f0), 16'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ss_n",  16'(SS_n), 16'd1);
    checkOutput("midrst_sclk",  16'(SCLK), 16'd1);
    checkOutput("midrst_mosi",  16'(MOSI), 16'd0);
    checkOutput("midrst_lft",   16'(lft_ld), 16'h000);
    checkOutput("midrst_rght",  16'(rght_ld), 16'h000);
    checkOutput("midrst_steer", 16'(steer_pot), 16'h000);
    checkOutput("midrst_batt",  16'(batt), 16'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    conv_num = 0;
    for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
    @(negedge clk);
    adc_val[0] = 12'h3C3;
    applyStimulus(0, 1'b0, 1'b1, lat);
    modelConv(ch);
    checkAll("post_rst", ch);

    // nxt already high in the first clk after reset release
    adc_val[0] = 12'h9E1;
    applyReset(1'b1);
    applyStimulus(0, 1'b0, 1'b0, lat);
    modelConv(ch);
    checkAll("nxt_at_release", ch);

    // nxt in the very clk the FSM returns to IDLE
    adc_val[4] = 12'h4B4;
    adc_val[5] = 12'hC0D;
    applyStimulus(0, 1'b1, 1'b1, lat);
    modelConv(ch);
    checkAll("b2b_first", ch);
    checkOutput("b2b_accept_ss_n", 16'(SS_n), 16'd0);
    applyStimulus(0, 1'b0, 1'b0, lat);
    modelConv(ch);
    checkAll("b2b_second", ch);

    // randomized conversions against the reference model
    applyReset(1'b0);
    for (int n = 0; n < 12; n++) begin
      int extra;
      for (int k = 0; k < 8; k++) adc_val[k] = 12'($urandom);
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 1000)) : 0;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus(extra, 1'b0, 1'b1, lat);
      modelConv(ch);
      checkAll($sformatf("rnd%0d", n), ch);
      ok = (lat >= 1025 && lat <= 1040) ? 16'd1 : 16'd0;
      checkOutput($sformatf("rnd%0d_latency_ok", n), ok, 16'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
